// File: rtl/spi_clkgen_if.sv
// rtl/spi_clkgen_if.sv - control/status bundle between the SPI sequencer and its user
interface spi_clkgen_if #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 16,
   parameter int CSD_WIDTH = 8
);
   logic                 en_i;
   logic                 cpol_i;
   logic [DIV_WIDTH-1:0] div_i;
   logic [CNT_WIDTH-1:0] cycles_i;
   logic [CSD_WIDTH-1:0] csd_i;
   logic                 start_i;
   logic                 abort_i;
   logic                 busy_o;
   logic                 cs_active_o;
   logic                 sck_o;
   logic                 pos_edge_o;
   logic                 neg_edge_o;
   logic                 done_o;

   modport master (
      output en_i, cpol_i, div_i, cycles_i, csd_i, start_i, abort_i,
      input  busy_o, cs_active_o, sck_o, pos_edge_o, neg_edge_o, done_o
   );

   modport slave (
      input  en_i, cpol_i, div_i, cycles_i, csd_i, start_i, abort_i,
      output busy_o, cs_active_o, sck_o, pos_edge_o, neg_edge_o, done_o
   );
endinterface

// File: rtl/spi_clkgen.sv
// rtl/spi_clkgen.sv - SCK divider with edge strobes and CS setup/run/hold sequencing
module spi_clkgen #(
   parameter int DIV_WIDTH = 16,
   parameter int CNT_WIDTH = 16,
   parameter int CSD_WIDTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   spi_clkgen_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SETUP, RUN, HOLD} state_t;

   state_t               state, state_nx;
   logic                 cpol_q, cpol_nx;
   logic [DIV_WIDTH-1:0] div_q, div_nx;
   logic [CNT_WIDTH-1:0] cycles_q, cycles_nx;
   logic [CSD_WIDTH-1:0] csd_q, csd_nx;
   logic [DIV_WIDTH-1:0] div_cnt, div_cnt_nx;
   logic [CNT_WIDTH:0]   tog_cnt, tog_cnt_nx;
   logic [CSD_WIDTH-1:0] csd_cnt, csd_cnt_nx;
   logic                 sck, sck_nx;
   logic                 pos, pos_nx;
   logic                 neg, neg_nx;
   logic                 done, done_nx;
   logic                 busy, busy_nx;
   logic [CNT_WIDTH:0]   tog_target;

   // Two toggles per SCK cycle; one extra bit keeps the maximum count wrap-free.
   assign tog_target = {cycles_q, 1'b0};

   // Next-state and next-output decode; every output is the registered copy of these.
   always_comb begin
      state_nx   = state;
      cpol_nx    = cpol_q;
      div_nx     = div_q;
      cycles_nx  = cycles_q;
      csd_nx     = csd_q;
      div_cnt_nx = div_cnt;
      tog_cnt_nx = tog_cnt;
      csd_cnt_nx = csd_cnt;
      sck_nx     = sck;
      pos_nx     = 1'b0;
      neg_nx     = 1'b0;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            sck_nx = bus.cpol_i;
            if (bus.start_i && bus.en_i && !bus.abort_i && (bus.cycles_i != '0)) begin
               cpol_nx    = bus.cpol_i;
               div_nx     = bus.div_i;
               cycles_nx  = bus.cycles_i;
               csd_nx     = bus.csd_i;
               csd_cnt_nx = '0;
               state_nx   = SETUP;
            end
         end
         SETUP: begin
            if (csd_cnt == csd_q) begin
               state_nx   = RUN;
               div_cnt_nx = '0;
               tog_cnt_nx = '0;
            end else begin
               csd_cnt_nx = csd_cnt + CSD_WIDTH'(1);
            end
         end
         RUN: begin
            if (tog_cnt == tog_target) begin
               // Final toggle is already visible; SCK rests at cpol from here.
               state_nx   = HOLD;
               csd_cnt_nx = '0;
            end else if (div_cnt == div_q) begin
               div_cnt_nx = '0;
               tog_cnt_nx = tog_cnt + (CNT_WIDTH+1)'(1);
               sck_nx     = ~sck;
               pos_nx     = ~sck;
               neg_nx     = sck;
            end else begin
               div_cnt_nx = div_cnt + DIV_WIDTH'(1);
            end
         end
         HOLD: begin
            if (csd_cnt == csd_q) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
               sck_nx   = cpol_q;
            end else begin
               csd_cnt_nx = csd_cnt + CSD_WIDTH'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
      // Abort or disable overrides everything, including a toggle due this cycle.
      if ((state != IDLE) && (bus.abort_i || !bus.en_i)) begin
         state_nx = IDLE;
         sck_nx   = cpol_q;
         pos_nx   = 1'b0;
         neg_nx   = 1'b0;
         done_nx  = 1'b0;
      end
      busy_nx = (state_nx != IDLE);
   end

   // State, latched configuration, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         cpol_q   <= 1'b0;
         div_q    <= '0;
         cycles_q <= '0;
         csd_q    <= '0;
         div_cnt  <= '0;
         tog_cnt  <= '0;
         csd_cnt  <= '0;
         sck      <= bus.cpol_i;
         pos      <= 1'b0;
         neg      <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         cpol_q   <= cpol_nx;
         div_q    <= div_nx;
         cycles_q <= cycles_nx;
         csd_q    <= csd_nx;
         div_cnt  <= div_cnt_nx;
         tog_cnt  <= tog_cnt_nx;
         csd_cnt  <= csd_cnt_nx;
         sck      <= sck_nx;
         pos      <= pos_nx;
         neg      <= neg_nx;
         done     <= done_nx;
         busy     <= busy_nx;
      end
   end

   assign bus.busy_o      = busy;
   assign bus.cs_active_o = busy;
   assign bus.sck_o       = sck;
   assign bus.pos_edge_o  = pos;
   assign bus.neg_edge_o  = neg;
   assign bus.done_o      = done;
endmodule

// File: tb/tb_spi_clkgen.sv
// tb/tb_spi_clkgen.sv - scoreboard bench for spi_clkgen edge, done and CS timing
module tb_spi_clkgen;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_clkgen_if bus ();
   spi_clkgen dut (.clk_i(clk), .rst_i(rst), .bus(bus));

   localparam logic [2:0] K_POS  = 3'b001;
   localparam logic [2:0] K_NEG  = 3'b010;
   localparam logic [2:0] K_DONE = 3'b100;

   typedef struct {
      int         cyc;
      logic [2:0] kind;
      logic       sck;
      logic       cs;
   } ev_t;

   ev_t exp_q[$];
   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   ev_t        mon_e;
   logic [2:0] mon_p;

   // Monitor: every strobe the DUT presents is matched against the next expected event.
   always @(negedge clk) begin
      mon_p = {bus.done_o, bus.neg_edge_o, bus.pos_edge_o};
      if (mon_p != 3'b000) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_strobe cycle=%0d strobes=%b required=none", cyc, mon_p);
         end else begin
            mon_e = exp_q.pop_front();
            if (cyc != mon_e.cyc || mon_p != mon_e.kind ||
                bus.sck_o != mon_e.sck || bus.cs_active_o != mon_e.cs) begin
               failures++;
               $display("FAIL strobe actual cycle=%0d strobes=%b sck=%b cs=%b required cycle=%0d strobes=%b sck=%b cs=%b",
                        cyc, mon_p, bus.sck_o, bus.cs_active_o,
                        mon_e.cyc, mon_e.kind, mon_e.sck, mon_e.cs);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d required=finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      int guard = 0;
      while (cyc < c && guard < 2000) begin
         tick(1);
         guard++;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic drain(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pending_events=%0d required=0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   function automatic logic [5:0] outs();
      return {bus.sck_o, bus.busy_o, bus.cs_active_o, bus.pos_edge_o, bus.neg_edge_o, bus.done_o};
   endfunction

   // Expected strobes for a transfer started (start_i sampled) in cycle t.
   // n_edges < 0 pushes every edge plus done; returns the done cycle.
   function automatic int push_xfer(input int t, input logic cpol, input int div,
                                    input int cycles, input int csd, input int n_edges);
      ev_t e;
      int  r = t + csd + 2;
      int  last = r + 2 * cycles * (div + 1);
      for (int k = 1; k <= 2 * cycles; k++) begin
         if (n_edges < 0 || k <= n_edges) begin
            e.cyc  = r + k * (div + 1);
            e.sck  = cpol ^ k[0];
            e.kind = e.sck ? K_POS : K_NEG;
            e.cs   = 1'b1;
            exp_q.push_back(e);
         end
      end
      if (n_edges < 0) begin
         e.cyc  = last + csd + 2;
         e.kind = K_DONE;
         e.sck  = cpol;
         e.cs   = 1'b0;
         exp_q.push_back(e);
      end
      return last + csd + 2;
   endfunction

   task automatic start_xfer(input logic cpol, input int div, input int cycles,
                             input int csd, output int t);
      bus.cpol_i   = cpol;
      bus.div_i    = 16'(div);
      bus.cycles_i = 16'(cycles);
      bus.csd_i    = 8'(csd);
      bus.start_i  = 1'b1;
      t = cyc;
      tick(1);
      bus.start_i = 1'b0;
   endtask

   int t, d;

   initial begin
      rst          = 1'b1;
      bus.en_i     = 1'b1;
      bus.cpol_i   = 1'b1;
      bus.div_i    = '0;
      bus.cycles_i = '0;
      bus.csd_i    = '0;
      bus.start_i  = 1'b0;
      bus.abort_i  = 1'b0;
      tick(2);
      rst = 1'b0;

      // Reset state with cpol=1 and no start: quiet for 20 cycles.
      for (int i = 0; i < 20; i++) begin
         chk("reset_idle", 32'(outs()), 32'b100000);
         tick(1);
      end

      // cpol=0 div=1 cycles=2 csd=0: hand-timed reference transfer.
      bus.cpol_i = 1'b0;
      tick(2);
      chk("idle_tracks_cpol", 32'(bus.sck_o), 32'd0);
      start_xfer(1'b0, 1, 2, 0, t);
      d = push_xfer(t, 1'b0, 1, 2, 0, -1);
      chk("ref_cs_at_t1", 32'({bus.cs_active_o, bus.busy_o}), 32'b11);
      wait_cyc(t + 11);
      chk("ref_cs_at_t11", 32'({bus.cs_active_o, bus.busy_o}), 32'b11);
      wait_cyc(t + 12);
      chk("ref_done_at_t12", 32'({bus.done_o, bus.busy_o, bus.cs_active_o}), 32'b100);
      chk("ref_done_cycle", 32'(d), 32'(t + 12));
      wait_cyc(t + 16);
      drain("drain_ref");

      // cpol=1 div=0 cycles=8 csd=2: edge every cycle, neg first, ends high.
      start_xfer(1'b1, 0, 8, 2, t);
      d = push_xfer(t, 1'b1, 0, 8, 2, -1);
      wait_cyc(d + 2);
      chk("fast_end_sck", 32'(bus.sck_o), 32'd1);
      drain("drain_fast");

      // Abort after the third edge: back to IDLE at once, nothing more.
      start_xfer(1'b0, 3, 4, 1, t);
      d = push_xfer(t, 1'b0, 3, 4, 1, 3);
      wait_cyc(t + 15);
      bus.abort_i = 1'b1;
      tick(1);
      bus.abort_i = 1'b0;
      chk("abort_outputs", 32'(outs()), 32'b000000);
      tick(30);
      drain("drain_abort");

      // en_i dropped in the cycle a toggle is scheduled: toggle suppressed.
      start_xfer(1'b1, 0, 4, 0, t);
      d = push_xfer(t, 1'b1, 0, 4, 0, 1);
      wait_cyc(t + 3);
      bus.en_i = 1'b0;
      tick(1);
      bus.en_i = 1'b1;
      chk("disable_outputs", 32'(outs()), 32'b100000);
      tick(10);
      drain("drain_disable");

      // cycles=0: start ignored.
      start_xfer(1'b0, 1, 0, 0, t);
      chk("zero_cycles_idle", 32'(outs()), 32'b000000);
      tick(10);
      drain("drain_zero_cycles");

      // start held during a transfer while div_i changes: latched div=1 timing, one done.
      bus.cpol_i   = 1'b0;
      bus.div_i    = 16'd1;
      bus.cycles_i = 16'd2;
      bus.csd_i    = 8'd0;
      bus.start_i  = 1'b1;
      t = cyc;
      d = push_xfer(t, 1'b0, 1, 2, 0, -1);
      wait_cyc(t + 3);
      bus.div_i = 16'd5;
      wait_cyc(t + 11);
      bus.start_i = 1'b0;
      wait_cyc(t + 20);
      drain("drain_held_start");

      // Reset pulsed in RUN after two edges, then a fresh full transfer.
      start_xfer(1'b0, 2, 3, 0, t);
      d = push_xfer(t, 1'b0, 2, 3, 0, 2);
      wait_cyc(t + 9);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("reset_in_run", 32'(outs()), 32'b000000);
      tick(8);
      drain("drain_reset_run");
      start_xfer(1'b1, 2, 3, 2, t);
      d = push_xfer(t, 1'b1, 2, 3, 2, -1);
      wait_cyc(d + 3);
      chk("after_reset_idle", 32'(outs()), 32'b100000);
      drain("drain_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
